// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem bus responder backed by an internal 64-bit RAM with wait states and range check
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] dmem_addr,
    input  logic [63:0] dmem_dout,
    input  logic [1:0]  dmem_write_width,
    input  logic        dmem_rstrobe,
    input  logic        dmem_wstrobe,
    output logic [63:0] dmem_din,
    output logic        dmem_cycle_complete,
    output logic        dmem_err
);
    localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_REARM  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  width_q, width_d;
    logic        store_q, store_d;
    logic [63:0] din_q, din_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0] rel;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [2:0]  offset;
    logic [5:0]  shift;
    logic [63:0] lane_mask;
    logic [63:0] rd_word;
    logic [63:0] wr_word;
    logic [63:0] ld_val;

    // BASE_ADDR is 8-byte aligned, so the lane offset comes straight from the latched address
    always_comb begin
        rel      = addr_q - BASE_ADDR;
        in_range = (rel < SPAN);
        idx      = rel[AW+2:3];
        case (width_q)
            2'd0:    begin offset = addr_q[2:0];            lane_mask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin offset = {addr_q[2:1], 1'b0};    lane_mask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin offset = {addr_q[2], 2'b00};     lane_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin offset = 3'd0;                   lane_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        shift   = {offset, 3'b000};
        rd_word = mem[idx];
        wr_word = (rd_word & ~(lane_mask << shift)) | ((data_q & lane_mask) << shift);
        ld_val  = (rd_word >> shift) & lane_mask;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        width_d = width_q;
        store_d = store_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_rstrobe || dmem_wstrobe) begin
                    addr_d  = dmem_addr;
                    data_d  = dmem_dout;
                    width_d = dmem_write_width;
                    store_d = dmem_wstrobe;
                    cnt_d   = 8'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_ACCESS: begin
                // Load data is registered here so it is already valid during the DONE cycle
                if (!store_q) din_d = in_range ? ld_val : 64'd0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_REARM;
            S_REARM: if (!dmem_rstrobe && !dmem_wstrobe) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 64'd0;
            data_q  <= 64'd0;
            width_q <= 2'd0;
            store_q <= 1'b0;
            din_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            width_q <= width_d;
            store_q <= store_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && store_q && in_range) mem[idx] <= wr_word;
    end

    assign dmem_din            = din_q;
    assign dmem_cycle_complete = (state_q == S_DONE);
    assign dmem_err            = (state_q == S_DONE) && !in_range;
endmodule
